// File: rtl/branch_flush_sched.sv
// ---------------------------------------------------------------------------
// branch_flush_sched
//   Sequences control-flow redirects for the 5-stage MIPS pipeline. Register
//   branches (jr/ber/bner) arrive from IF/ID and immediate branches/jumps
//   (j/be/bne) from EX/MEM. The older EX/MEM request wins. A redirect is held
//   while fetch is stalled, issued for exactly one cycle, then followed by a
//   shadow window in which wrong-path requests are dropped.
//
// Ports:
//   CLK, RST                    clock, async active-high reset
//   IFID_OPCODE/TAKEN/TARGET    IF/ID redirect source
//   EXMEM_OPCODE/TAKEN/TARGET   EX/MEM redirect source
//   STALL_IF                    fetch cannot take a new PC this cycle
//   CLR_CNT                     synchronous clear of REDIR_CNT
//   PC_SEL, PC_TARGET           PC mux select (0 seq, 1 EX/MEM, 2 IF/ID) and target
//   FLUSH_IFID/IDEX/EXMEM       pipeline register flush strobes
//   BUSY                        redirect held, issuing or in shadow
//   REDIR_CNT                   saturating count of issued redirects
// ---------------------------------------------------------------------------
module branch_flush_sched #(
    parameter int AW         = 32,
    parameter int SHADOW_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       IFID_OPCODE,
    input  logic             IFID_TAKEN,
    input  logic [AW-1:0]    IFID_TARGET,
    input  logic [4:0]       EXMEM_OPCODE,
    input  logic             EXMEM_TAKEN,
    input  logic [AW-1:0]    EXMEM_TARGET,
    input  logic             STALL_IF,
    input  logic             CLR_CNT,
    output logic [1:0]       PC_SEL,
    output logic [AW-1:0]    PC_TARGET,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic             FLUSH_EXMEM,
    output logic             BUSY,
    output logic [CNT_W-1:0] REDIR_CNT
);

    localparam logic [4:0] OP_J    = 5'b10111;
    localparam logic [4:0] OP_BE   = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b11000;
    localparam logic [4:0] OP_BER  = 5'b10110;
    localparam logic [4:0] OP_BNER = 5'b10101;

    localparam logic [2:0]       SH_INIT = 3'(SHADOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_ISSUE,
        S_SHADOW
    } state_t;

    state_t           state, state_nx;
    logic             src_ex, src_ex_nx;   // 1 = EX/MEM source, 0 = IF/ID source
    logic [AW-1:0]    tgt, tgt_nx;
    logic [2:0]       sh_cnt, sh_cnt_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             ereq, ireq;

    assign ereq = (EXMEM_OPCODE == OP_J) ||
                  (((EXMEM_OPCODE == OP_BE) || (EXMEM_OPCODE == OP_BNE)) && EXMEM_TAKEN);
    assign ireq = (IFID_OPCODE == OP_JR) ||
                  (((IFID_OPCODE == OP_BER) || (IFID_OPCODE == OP_BNER)) && IFID_TAKEN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            src_ex    <= 1'b0;
            tgt       <= '0;
            sh_cnt    <= '0;
            REDIR_CNT <= '0;
        end else begin
            state     <= state_nx;
            src_ex    <= src_ex_nx;
            tgt       <= tgt_nx;
            sh_cnt    <= sh_cnt_nx;
            REDIR_CNT <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        src_ex_nx = src_ex;
        tgt_nx    = tgt;
        sh_cnt_nx = sh_cnt;
        case (state)
            S_IDLE: begin
                if (ereq) begin
                    src_ex_nx = 1'b1;
                    tgt_nx    = EXMEM_TARGET;
                end else if (ireq) begin
                    src_ex_nx = 1'b0;
                    tgt_nx    = IFID_TARGET;
                end
                if (ereq || ireq)
                    state_nx = STALL_IF ? S_HOLD : S_ISSUE;
            end
            S_HOLD: begin
                // A younger IF/ID redirect is superseded by an older EX/MEM one;
                // an EX/MEM redirect already held is final.
                if (ereq && !src_ex) begin
                    src_ex_nx = 1'b1;
                    tgt_nx    = EXMEM_TARGET;
                end
                if (!STALL_IF)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                state_nx  = S_SHADOW;
                sh_cnt_nx = SH_INIT;
            end
            S_SHADOW: begin
                if (sh_cnt == 3'd0)
                    state_nx = S_IDLE;
                else
                    sh_cnt_nx = sh_cnt - 3'd1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Count on entry to ISSUE so the new value is visible in the issue cycle.
    always_comb begin
        cnt_nx = REDIR_CNT;
        if (CLR_CNT)
            cnt_nx = '0;
        else if ((state_nx == S_ISSUE) && (REDIR_CNT != CNT_MAX))
            cnt_nx = REDIR_CNT + 1'b1;
    end

    // Outputs decode registered state only: no input-to-output path.
    always_comb begin
        PC_SEL      = 2'd0;
        PC_TARGET   = '0;
        FLUSH_IFID  = 1'b0;
        FLUSH_IDEX  = 1'b0;
        FLUSH_EXMEM = 1'b0;
        if (state == S_ISSUE) begin
            PC_SEL      = src_ex ? 2'd1 : 2'd2;
            PC_TARGET   = tgt;
            FLUSH_IFID  = 1'b1;
            FLUSH_IDEX  = src_ex;
            FLUSH_EXMEM = src_ex;
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_branch_flush_sched.sv
module tb_branch_flush_sched;

    localparam logic [4:0] OP_J    = 5'b10111;
    localparam logic [4:0] OP_BE   = 5'b10100;
    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b11000;
    localparam logic [4:0] OP_BER  = 5'b10110;
    localparam logic [4:0] OP_BNER = 5'b10101;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  IFID_OPCODE, EXMEM_OPCODE;
    logic        IFID_TAKEN, EXMEM_TAKEN;
    logic [31:0] IFID_TARGET, EXMEM_TARGET;
    logic        STALL_IF, CLR_CNT;
    logic [1:0]  PC_SEL;
    logic [31:0] PC_TARGET;
    logic        FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM, BUSY;
    logic [3:0]  REDIR_CNT;

    branch_flush_sched #(.AW(32), .SHADOW_CYC(2), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .IFID_OPCODE(IFID_OPCODE), .IFID_TAKEN(IFID_TAKEN), .IFID_TARGET(IFID_TARGET),
        .EXMEM_OPCODE(EXMEM_OPCODE), .EXMEM_TAKEN(EXMEM_TAKEN), .EXMEM_TARGET(EXMEM_TARGET),
        .STALL_IF(STALL_IF), .CLR_CNT(CLR_CNT),
        .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET),
        .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX), .FLUSH_EXMEM(FLUSH_EXMEM),
        .BUSY(BUSY), .REDIR_CNT(REDIR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [2:0]  fl;   // {ifid, idex, exmem}
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] exp_cnt = 4'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        IFID_OPCODE = 5'd0; IFID_TAKEN = 1'b0; IFID_TARGET = 32'd0;
        EXMEM_OPCODE = 5'd0; EXMEM_TAKEN = 1'b0; EXMEM_TARGET = 32'd0;
    endtask

    task automatic bump();
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [31:0] tgt, input logic [2:0] fl);
        exp_t e;
        e.sel = sel; e.tgt = tgt; e.fl = fl; e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Unstalled redirect: request, one ISSUE cycle, two shadow cycles, idle.
    task automatic go(input string nm,
                      input logic [4:0] eop, input logic etk, input logic [31:0] et,
                      input logic [4:0] iop, input logic itk, input logic [31:0] it,
                      input logic [1:0] xsel, input logic [31:0] xtgt, input logic [2:0] xfl);
        step();
        EXMEM_OPCODE = eop; EXMEM_TAKEN = etk; EXMEM_TARGET = et;
        IFID_OPCODE = iop;  IFID_TAKEN = itk;  IFID_TARGET = it;
        STALL_IF = 1'b0;
        bump();
        push(xsel, xtgt, xfl);
        step();
        clr_in();
        chk({nm, "_issue_sel"}, 32'(PC_SEL), 32'(xsel));
        chk({nm, "_issue_busy"}, 32'(BUSY), 32'd1);
        step();
        chk({nm, "_shadow1_busy"}, 32'(BUSY), 32'd1);
        step();
        chk({nm, "_shadow2_busy"}, 32'(BUSY), 32'd1);
        step();
        chk({nm, "_idle_busy"}, 32'(BUSY), 32'd0);
    endtask

    // Monitor: every issued redirect must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (PC_SEL != 2'd0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_redirect_sel", 32'(PC_SEL), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc_sel", 32'(PC_SEL), 32'(e.sel));
                        chk("sb_pc_target", PC_TARGET, e.tgt);
                        chk("sb_flushes", 32'({FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}), 32'(e.fl));
                        chk("sb_redir_cnt", 32'(REDIR_CNT), 32'(e.cnt));
                    end
                end else begin
                    chk("quiet_outputs", {PC_TARGET[28:0], FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}, 32'd0);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; STALL_IF = 1'b0; CLR_CNT = 1'b0;
        clr_in();
        repeat (2) step();
        chk("rst_pc_sel", 32'(PC_SEL), 32'd0);
        chk("rst_target", PC_TARGET, 32'd0);
        chk("rst_flushes", 32'({FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_cnt", 32'(REDIR_CNT), 32'd0);
        RST = 1'b0;

        // be taken, unstalled
        go("be_taken", OP_BE, 1'b1, 32'h40, 5'd0, 1'b0, 32'd0, 2'd1, 32'h40, 3'b111);
        chk("be_taken_cnt", 32'(REDIR_CNT), 32'd1);

        // jr and bne in the same cycle: EX/MEM wins
        go("prio", OP_BNE, 1'b1, 32'h200, OP_JR, 1'b0, 32'h100, 2'd1, 32'h200, 3'b111);

        // bner held under stall, replaced by j
        step();
        IFID_OPCODE = OP_BNER; IFID_TAKEN = 1'b1; IFID_TARGET = 32'h80; STALL_IF = 1'b1;
        step();
        clr_in();
        EXMEM_OPCODE = OP_J; EXMEM_TARGET = 32'h300;
        chk("hold1_busy", 32'(BUSY), 32'd1);
        chk("hold1_sel", 32'(PC_SEL), 32'd0);
        step();
        clr_in();
        chk("hold2_busy", 32'(BUSY), 32'd1);
        step();
        STALL_IF = 1'b0;
        chk("hold3_sel", 32'(PC_SEL), 32'd0);
        bump();
        push(2'd1, 32'h300, 3'b111);
        step();
        chk("hold_issue_sel", 32'(PC_SEL), 32'd1);
        step();
        chk("hold_after_sel", 32'(PC_SEL), 32'd0);
        step(); step();
        chk("hold_idle_busy", 32'(BUSY), 32'd0);

        // ber taken, jr presented during shadow is dropped
        step();
        IFID_OPCODE = OP_BER; IFID_TAKEN = 1'b1; IFID_TARGET = 32'h44;
        bump();
        push(2'd2, 32'h44, 3'b100);
        step();
        clr_in();
        chk("ber_issue_sel", 32'(PC_SEL), 32'd2);
        step();
        IFID_OPCODE = OP_JR; IFID_TARGET = 32'h999;
        step();
        chk("ber_shadow2_busy", 32'(BUSY), 32'd1);
        step();
        clr_in();
        chk("ber_idle_busy", 32'(BUSY), 32'd0);
        chk("ber_cnt", 32'(REDIR_CNT), 32'(exp_cnt));

        // non-requests
        step();
        EXMEM_OPCODE = OP_BE; EXMEM_TAKEN = 1'b0; EXMEM_TARGET = 32'h77;
        step();
        chk("be_nt_busy", 32'(BUSY), 32'd0);
        clr_in();
        EXMEM_TAKEN = 1'b1; IFID_TAKEN = 1'b1; IFID_TARGET = 32'h55; EXMEM_TARGET = 32'h66;
        step();
        chk("op0_busy_a", 32'(BUSY), 32'd0);
        step();
        chk("op0_busy_b", 32'(BUSY), 32'd0);
        clr_in();

        // saturation of the 4-bit counter
        for (int i = 0; i < 13; i++)
            go("sat", OP_J, 1'b0, 32'h1000 + 32'(i * 4), 5'd0, 1'b0, 32'd0, 2'd1,
               32'h1000 + 32'(i * 4), 3'b111);
        chk("sat_cnt", 32'(REDIR_CNT), 32'd15);

        // clear coincident with issue
        step();
        EXMEM_OPCODE = OP_J; EXMEM_TARGET = 32'h500; CLR_CNT = 1'b1;
        exp_cnt = 4'd0;
        push(2'd1, 32'h500, 3'b111);
        step();
        clr_in();
        chk("clr_issue_sel", 32'(PC_SEL), 32'd1);
        step();
        CLR_CNT = 1'b0;
        chk("clr_cnt_a", 32'(REDIR_CNT), 32'd0);
        step(); step();
        chk("clr_cnt_b", 32'(REDIR_CNT), 32'd0);
        chk("clr_idle_busy", 32'(BUSY), 32'd0);

        // reset mid-HOLD
        step();
        IFID_OPCODE = OP_JR; IFID_TARGET = 32'h10; STALL_IF = 1'b1;
        step();
        clr_in();
        chk("rhold_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rhold_async_busy", 32'(BUSY), 32'd0);
        chk("rhold_async_sel", 32'(PC_SEL), 32'd0);
        chk("rhold_async_cnt", 32'(REDIR_CNT), 32'd0);
        step();
        RST = 1'b0; STALL_IF = 1'b0;
        EXMEM_OPCODE = OP_J; EXMEM_TARGET = 32'h600;
        exp_cnt = 4'd0;
        bump();
        push(2'd1, 32'h600, 3'b111);
        step();
        clr_in();
        chk("post_rst_issue_sel", 32'(PC_SEL), 32'd1);
        step(); step(); step();
        chk("post_rst_idle_busy", 32'(BUSY), 32'd0);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/branch_flush_sched.md
Name: branch_flush_sched

Overview:
- Sequences control-flow redirects for the 5-stage MIPS pipeline.
- Accepts taken-branch/jump requests from two sources: register branches resolved in IF/ID (jr, ber, bner) and immediate branches/jumps resolved in EX/MEM (j, be, bne).
- Prioritises the two sources and holds a redirect while fetch is stalled.
- Drives the PC mux select/target and the IFID/IDEX/EXMEM flush strobes, then suppresses wrong-path requests for a shadow window.

Parameters:
AW, 32, width of PC target
SHADOW_CYC, 2, cycles after an issued redirect during which new requests are ignored (legal range 1..7)
CNT_W, 16, width of the redirect counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
IFID_OPCODE  in  5  opcode in IF/ID
IFID_TAKEN  in  1  register-branch condition true (ber/bner)
IFID_TARGET  in  AW  target for IF/ID redirect
EXMEM_OPCODE  in  5  opcode in EX/MEM
EXMEM_TAKEN  in  1  immediate-branch condition true (be/bne)
EXMEM_TARGET  in  AW  target for EX/MEM redirect
STALL_IF  in  1  fetch cannot accept a new PC this cycle
CLR_CNT  in  1  synchronous clear of REDIR_CNT
PC_SEL  out  2  0 = sequential, 1 = EX/MEM target, 2 = IF/ID target (3 never driven)
PC_TARGET  out  AW  redirect target; valid when PC_SEL != 0
FLUSH_IFID  out  1  flush IF/ID
FLUSH_IDEX  out  1  flush ID/EX
FLUSH_EXMEM  out  1  flush EX/MEM
BUSY  out  1  a redirect is held, issuing, or in shadow
REDIR_CNT  out  CNT_W  saturating count of issued redirects

Behaviour:
- Opcodes: j = 10111, be = 10100, bne = 10011, jr = 11000, ber = 10110, bner = 10101.
- Request decode (combinational):
  - EX/MEM request (EREQ) = (op == j) OR ((op == be OR op == bne) AND EXMEM_TAKEN).
  - IF/ID request (IREQ) = (op == jr) OR ((op == ber OR op == bner) AND IFID_TAKEN).
  - Any other opcode never requests.
- Held registers: src (EX or ID) and tgt (AW bits).
- Priority: EREQ beats IREQ when both are present (older instruction wins).
- State machine:
  - IDLE:
    - EREQ or IREQ → capture winning src/tgt.
    - STALL_IF = 0 → ISSUE.
    - STALL_IF = 1 → HOLD.
  - HOLD:
    - EREQ this cycle while held src = ID → replace with EX src/tgt.
    - Held src = EX is never replaced.
    - IREQ is ignored.
    - STALL_IF = 0 → ISSUE; the replacement check applies in the same cycle.
  - ISSUE (exactly one cycle):
    - All requests are ignored.
    - Next state is SHADOW with shadow counter = SHADOW_CYC - 1.
  - SHADOW:
    - All requests are ignored.
    - Counter = 0 → IDLE; otherwise decrement.
- Outputs are registered and decoded from state/held registers; no input-to-output combinational path.
- Redirect latency: request in cycle N with STALL_IF = 0 → outputs asserted in cycle N+1.
- In ISSUE:
  - src = EX: PC_SEL = 1, all three flushes = 1.
  - src = ID: PC_SEL = 2, FLUSH_IFID = 1, FLUSH_IDEX = 0, FLUSH_EXMEM = 0.
  - PC_TARGET = tgt.
- Outside ISSUE: PC_SEL = 0, all flushes = 0, PC_TARGET = 0.
- BUSY = 1 in HOLD, ISSUE and SHADOW.
- REDIR_CNT:
  - Increments by 1 in each ISSUE cycle.
  - Saturates at all-ones.
  - CLR_CNT zeroes it; if CLR_CNT and ISSUE coincide, clear wins.
- STALL_IF rising during ISSUE does not extend ISSUE; the fetch stage must latch the PC.
- Reset (any time, including mid HOLD/SHADOW):
  - State = IDLE; src, tgt and shadow counter = 0.
  - All outputs = 0 immediately, asynchronously.
  - First request is accepted in the first clock after RST deasserts.

Test Plan:
- be with EXMEM_TAKEN = 1, target 0x0000_0040, STALL_IF = 0 at cycle 5 → cycle 6: PC_SEL = 1, PC_TARGET = 0x40, all flushes = 1, REDIR_CNT = 1; cycles 7-8: BUSY = 1, outputs 0; cycle 9: IDLE.
- jr target 0x100 and bne taken target 0x200 in the same cycle → next cycle PC_SEL = 1, PC_TARGET = 0x200, all flushes = 1; the jr is dropped.
- bner taken target 0x80 with STALL_IF = 1 for 3 cycles, EXMEM_OPCODE = j target 0x300 in the 2nd cycle → after STALL_IF drops: one ISSUE cycle with PC_SEL = 1, PC_TARGET = 0x300, all flushes = 1.
- ber taken target 0x44 → ISSUE with FLUSH_IFID = 1 only, PC_SEL = 2; a jr presented during the 2 shadow cycles → no second redirect, REDIR_CNT increments by exactly 1.
- be with EXMEM_TAKEN = 0, and opcode 00000 with both TAKEN inputs = 1 → no redirect, BUSY = 0 throughout.
- RST pulse mid-HOLD → outputs 0 at once, state IDLE; REDIR_CNT preset near max with CNT_W = 4 → saturates at 15; CLR_CNT together with ISSUE → 0.
